// File: rtl/breakout_pkg.sv
// Shared types and defaults for the breakout game sequencer.
package breakout_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    OVER  = 3'd4,
    WON   = 3'd5
  } game_state_t;

  localparam int DEFAULT_LIVES  = 3;
  localparam int DEFAULT_BRICKS = 50;

endpackage

// File: rtl/breakout_game_ctrl_serve_timer.sv
// Serve delay timer: counts frame_tick pulses while enabled, done when the
// count equals SERVE_FRAMES. clear has priority and holds the count at zero.
module serve_timer #(
  parameter int SERVE_FRAMES = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic frame_tick,
  output logic done
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  logic [CW-1:0] count_reg;

  assign done = (count_reg == CW'(SERVE_FRAMES));

  // Frame counter; stops at the target so it never overshoots before clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en && frame_tick && !done) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: IDLE -> SERVE -> PLAY -> LOST/WON/OVER.
// Owns lives, score and bricks-remaining; gates the ball/paddle datapath.
// Optional feature: define HISCORE_EN to add the hi_score output.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int LIVES        = DEFAULT_LIVES,
  parameter int SERVE_FRAMES = 60,
  parameter int NUM_BRICKS   = DEFAULT_BRICKS,
  parameter int SCORE_W      = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               ball_lost,
  input  logic [1:0]         hit_count,
  output logic [2:0]         state,
  output logic               play_en,
  output logic               serve,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               game_won
`ifdef HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hi_score
`endif
);

  localparam int BW = $clog2(NUM_BRICKS + 1);

  game_state_t        state_reg, state_next;
  logic [2:0]         lives_reg, lives_next, lives_dec;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [SCORE_W:0]   score_sum;
  logic [BW-1:0]      bricks_left_reg, bricks_left_next;
  logic               serve_reg, serve_next;
  logic               play_en_reg, game_over_reg, game_won_reg;
  logic               start_q;
  logic               start_rise;
  logic               timer_done;

  assign start_rise = start & ~start_q;
  assign lives_dec  = lives_reg - 3'd1;

  // Timer runs only in SERVE and restarts from zero on every SERVE entry.
  serve_timer #(
    .SERVE_FRAMES(SERVE_FRAMES)
  ) u_serve_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     ((state_reg != SERVE) || timer_done),
    .en        (state_reg == SERVE),
    .frame_tick(frame_tick),
    .done      (timer_done)
  );

  // Next-state and counter updates; PLAY is the only state that uses hits.
  always_comb begin
    state_next       = state_reg;
    lives_next       = lives_reg;
    score_next       = score_reg;
    bricks_left_next = bricks_left_reg;
    serve_next       = 1'b0;
    score_sum        = {1'b0, score_reg} + (SCORE_W + 1)'(hit_count);
    case (state_reg)
      IDLE: begin
        if (start_rise) begin
          state_next       = SERVE;
          lives_next       = 3'(LIVES);
          score_next       = '0;
          bricks_left_next = BW'(NUM_BRICKS);
          serve_next       = 1'b1;
        end
      end
      SERVE: begin
        if (timer_done) begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        // Clearing the last brick wins even if the ball is lost this cycle.
        if (BW'(hit_count) >= bricks_left_reg) begin
          bricks_left_next = '0;
          state_next       = WON;
        end else begin
          bricks_left_next = bricks_left_reg - BW'(hit_count);
          if (ball_lost) begin
            state_next = LOST;
          end
        end
      end
      LOST: begin
        lives_next = lives_dec;
        if (lives_dec != 3'd0) begin
          state_next = SERVE;
          serve_next = 1'b1;
        end else begin
          state_next = OVER;
        end
      end
      OVER, WON: begin
        if (start_rise) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      lives_reg       <= 3'(LIVES);
      score_reg       <= '0;
      bricks_left_reg <= BW'(NUM_BRICKS);
      serve_reg       <= 1'b0;
      play_en_reg     <= 1'b0;
      game_over_reg   <= 1'b0;
      game_won_reg    <= 1'b0;
      start_q         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lives_reg       <= lives_next;
      score_reg       <= score_next;
      bricks_left_reg <= bricks_left_next;
      serve_reg       <= serve_next;
      play_en_reg     <= (state_next == PLAY);
      game_over_reg   <= (state_next == OVER);
      game_won_reg    <= (state_next == WON);
      start_q         <= start;
    end
  end

`ifdef HISCORE_EN
  logic [SCORE_W-1:0] hi_score_reg;
  logic               end_entry;

  assign end_entry = ((state_next == OVER) || (state_next == WON)) &&
                     !((state_reg == OVER) || (state_reg == WON));

  // Best score is captured once per game, including the final cycle's hits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_score_reg <= '0;
    end else if (end_entry && (score_next > hi_score_reg)) begin
      hi_score_reg <= score_next;
    end
  end

  assign hi_score = hi_score_reg;
`endif

  assign state     = state_reg;
  assign play_en   = play_en_reg;
  assign serve     = serve_reg;
  assign lives     = lives_reg;
  assign score     = score_reg;
  assign game_over = game_over_reg;
  assign game_won  = game_won_reg;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Testbench for breakout_game_ctrl: directed game sequences, a reference
// model checked every cycle, and hand-computed literal expectations.
// Build with HISCORE_EN defined to also exercise hi_score.
module tb_breakout_game_ctrl;
  import breakout_pkg::*;

  localparam int LIVES        = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int NUM_BRICKS   = 50;
  localparam int SCORE_W      = 10;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic ball_lost = 1'b0;
  logic [1:0] hit_count = 2'd0;
  logic [2:0] state;
  logic play_en, serve;
  logic [2:0] lives;
  logic [SCORE_W-1:0] score;
  logic game_over, game_won;
`ifdef HISCORE_EN
  logic [SCORE_W-1:0] hi_score;
`endif

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  breakout_game_ctrl #(
    .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES),
    .NUM_BRICKS(NUM_BRICKS), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .ball_lost(ball_lost), .hit_count(hit_count), .state(state),
    .play_en(play_en), .serve(serve), .lives(lives), .score(score),
    .game_over(game_over), .game_won(game_won)
`ifdef HISCORE_EN
    , .hi_score(hi_score)
`endif
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Reference model: game rules in plain integer arithmetic.
  int m_state, m_prev, m_lives, m_score, m_bricks, m_ticks, m_hi, m_nb;
  bit m_serve, m_start_q, m_rise;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = IDLE; m_lives = LIVES; m_score = 0; m_bricks = NUM_BRICKS;
      m_ticks = 0; m_serve = 0; m_start_q = 0; m_hi = 0;
    end else begin
      m_rise = start && !m_start_q;
      m_start_q = start;
      m_serve = 0;
      m_prev = m_state;
      if (m_state == IDLE) begin
        if (m_rise) begin
          m_state = SERVE; m_lives = LIVES; m_score = 0;
          m_bricks = NUM_BRICKS; m_serve = 1; m_ticks = 0;
        end
      end else if (m_state == SERVE) begin
        if (m_ticks >= SERVE_FRAMES) begin m_state = PLAY; m_ticks = 0; end
        else if (frame_tick) m_ticks++;
      end else if (m_state == PLAY) begin
        m_score = (m_score + hit_count > SCORE_MAX) ? SCORE_MAX : m_score + hit_count;
        m_nb = m_bricks - hit_count;
        if (m_nb <= 0) begin m_bricks = 0; m_state = WON; end
        else begin m_bricks = m_nb; if (ball_lost) m_state = LOST; end
      end else if (m_state == LOST) begin
        m_lives--;
        if (m_lives > 0) begin m_state = SERVE; m_serve = 1; m_ticks = 0; end
        else m_state = OVER;
      end else begin
        if (m_rise) m_state = IDLE;
      end
      if ((m_state == OVER || m_state == WON) && !(m_prev == OVER || m_prev == WON))
        m_hi = (m_score > m_hi) ? m_score : m_hi;
    end
  end

  // Every-cycle comparison against the model, sampled after the edge settles.
  initial begin
    forever begin
      @(posedge clk); #1;
      check("cmp_state", state, m_state);
      check("cmp_play_en", play_en, (m_state == PLAY) ? 1 : 0);
      check("cmp_serve", serve, m_serve);
      check("cmp_lives", lives, m_lives);
      check("cmp_score", score, m_score);
      check("cmp_game_over", game_over, (m_state == OVER) ? 1 : 0);
      check("cmp_game_won", game_won, (m_state == WON) ? 1 : 0);
      check("cmp_bricks", int'(dut.bricks_left_reg), m_bricks);
`ifdef HISCORE_EN
      check("cmp_hi_score", hi_score, m_hi);
`endif
    end
  end

  // One clock edge with the given inputs; returns at the following negedge.
  task automatic cyc(input bit t, input bit s, input bit l, input int h);
    frame_tick = t; start = s; ball_lost = l; hit_count = 2'(h);
    @(negedge clk);
  endtask

  // Ticks through SERVE while throwing hits/losses that must be ignored.
  task automatic serve_to_play();
    int k;
    for (int i = 0; i < SERVE_FRAMES; i++) begin
      cyc(1, 0, 1, 3);
      cyc(0, 0, 1, 3);
    end
    k = 0;
    while (state != PLAY && k < 4) begin
      cyc(0, 0, 0, 0);
      k++;
    end
    check("reach_play", state, PLAY);
    check("play_en_in_play", play_en, 1);
  endtask

  task automatic lose_ball(input int lives_after);
    cyc(0, 0, 1, 0);
    check("lost_state", state, LOST);
    check("lost_play_en", play_en, 0);
    cyc(0, 0, 0, 0);
    check("lives_after_loss", lives, lives_after);
    if (lives_after > 0) begin
      check("reserve_state", state, SERVE);
      check("reserve_pulse", serve, 1);
    end else begin
      check("over_state", state, OVER);
      check("game_over", game_over, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", state, IDLE);
    check("rst_lives", lives, 3);
    check("rst_score", score, 0);
    check("rst_play_en", play_en, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0);

    // Game 1: two balls, win with simultaneous last brick and ball loss.
    cyc(1, 1, 0, 0);
    check("g1_serve_state", state, SERVE);
    check("g1_serve_pulse", serve, 1);
    cyc(0, 0, 0, 0);
    check("g1_serve_one_cycle", serve, 0);
    serve_to_play();
    repeat (3) cyc(0, 0, 0, 2);
    check("g1_score6", score, 6);
    check("g1_bricks44", int'(dut.bricks_left_reg), 44);
    lose_ball(2);
    serve_to_play();
    repeat (14) cyc(0, 0, 0, 3);
    cyc(0, 0, 0, 1);
    check("g1_score49", score, 49);
    check("g1_bricks1", int'(dut.bricks_left_reg), 1);
    cyc(0, 1, 1, 3);
    check("g1_won_state", state, WON);
    check("g1_won_score", score, 52);
    check("g1_won_lives", lives, 2);
    check("g1_won_bricks", int'(dut.bricks_left_reg), 0);
    check("g1_game_won", game_won, 1);
    repeat (3) cyc(0, 1, 0, 0);
    check("g1_held_start_stays_won", state, WON);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("g1_back_to_idle", state, IDLE);
    cyc(0, 0, 0, 0);
`ifdef HISCORE_EN
    check("g1_hi_score", hi_score, 52);
`endif

    // Game 2: reset asserted mid-PLAY.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    serve_to_play();
    cyc(0, 0, 0, 3); cyc(0, 0, 0, 3); cyc(0, 0, 0, 1);
    check("g2_score7", score, 7);
    reset = 1'b0;
    @(posedge clk); #1;
    check("g2_rst_state", state, IDLE);
    check("g2_rst_score", score, 0);
    check("g2_rst_lives", lives, 3);
    check("g2_rst_play_en", play_en, 0);
    check("g2_rst_no_serve", serve, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 0);

    // Game 3: score 12, lose all balls.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    serve_to_play();
    repeat (4) cyc(0, 0, 0, 3);
    check("g3_score12", score, 12);
    lose_ball(2);
    serve_to_play();
    lose_ball(1);
    serve_to_play();
    lose_ball(0);
`ifdef HISCORE_EN
    check("g3_hi_score", hi_score, 12);
`endif
    cyc(0, 1, 0, 0);
    check("g3_over_to_idle", state, IDLE);
    cyc(0, 0, 0, 0);

    // Game 4: score 5, lower than the best.
    cyc(0, 1, 0, 0);
    check("g4_lives_reload", lives, 3);
    check("g4_score_reload", score, 0);
    cyc(0, 0, 0, 0);
    serve_to_play();
    cyc(0, 0, 0, 3); cyc(0, 0, 0, 2);
    lose_ball(2);
    serve_to_play();
    lose_ball(1);
    serve_to_play();
    lose_ball(0);
    check("g4_score5", score, 5);
`ifdef HISCORE_EN
    check("g4_hi_score_kept", hi_score, 12);
`endif
    cyc(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
